comparator_seq_tx: RTL and testbench
====================================

// Module: comparator_seq_tx
// PURPOSE
//  Transmit side of the bit-serial compare link. Accepts two WIDTH-bit operands on a valid/ready
//  handshake, clears the serial comparator, then streams the operand bit pairs LSB-first on ser_a/ser_b.
//  The LSB-first order is required because the comparator's latest differing bit decides the result.
//  Samples the comparator's eq/gt/lt on the last bit and returns a registered result on a second handshake.
//  Sits between a parallel producer and one bit-serial comparator instance.
// PARAMETERS
//  WIDTH   8   operand width in bits; legal range WIDTH >= 1
// PORTS
//  clk        in   1      single clock, all state updates on posedge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block can accept an operand pair
//  in_a       in   WIDTH  operand A, unsigned
//  in_b       in   WIDTH  operand B, unsigned
//  ser_a      out  1      serial bit of A to comparator
//  ser_b      out  1      serial bit of B to comparator
//  cmp_rst_n  out  1      active-low clear to comparator
//  cmp_eq     in   1      comparator eq (combinational from current ser bits)
//  cmp_gt     in   1      comparator gt
//  cmp_lt     in   1      comparator lt
//  res_valid  out  1      result valid
//  res_ready  in   1      consumer takes result
//  res_eq     out  1      captured eq flag
//  res_gt     out  1      captured gt flag
//  res_lt     out  1      captured lt flag
//  res_err    out  1      captured flags were not exactly one-hot
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
//  - Registered outputs: every output is registered.
//  - Reset values: state=IDLE, in_ready=0, ser_a=ser_b=0, cmp_rst_n=0 (comparator held clear),
//    res_valid=0, res_*=0. The first cycle after reset is IDLE: in_ready=1, cmp_rst_n=1.
//  - FSM: IDLE -> CLEAR -> SHIFT -> DONE -> IDLE.
//    IDLE:  in_ready=1. On in_valid&in_ready: latch in_a/in_b into shift regs, clear bit counter,
//           go to CLEAR. in_ready drops on the same edge.
//    CLEAR: exactly one cycle with cmp_rst_n=0 and ser_a=ser_b=0. Load bit 0 onto ser_a/ser_b.
//    SHIFT: WIDTH cycles, cnt 0..WIDTH-1; cmp_rst_n=1 and ser_a/ser_b = bit cnt of A/B.
//           The comparator registers the bit pair on the closing edge of each cycle.
//           On the edge closing cnt=WIDTH-1: capture cmp_eq/gt/lt into res_*,
//           res_err = !(exactly one of the three set), and go to DONE.
//    DONE:  res_valid=1; outputs held stable until res_valid&res_ready, then go to IDLE.
//           ser_a/ser_b return to 0.
//  - Latency: accept edge at cycle 0, CLEAR at cycle 1, SHIFT at cycles 2..WIDTH+1,
//    res_valid first high in cycle WIDTH+2.
//  - Throughput: one transaction per WIDTH+3 cycles minimum. A new operand pair cannot be accepted
//    while DONE is pending, so in_valid during DONE waits.
//  - Counter: width max(1,$clog2(WIDTH)). WIDTH=1 gives a single SHIFT cycle; no wrap beyond WIDTH-1.
//  - Reset mid-transaction (any state): abort, all outputs to reset values on the next edge,
//    and no res_valid for the aborted pair.
//  - Input handling: in_a/in_b may change freely after the accept edge; cmp_* inputs are ignored
//    outside the final SHIFT cycle.
// STRUCTURE
//  - Shared include comparator_defs.vh: FSM state encodings (IDLE/CLEAR/SHIFT/DONE, 2-bit) and the
//    result flag bit positions {eq,gt,lt}, both shared with the comparator testbench.
//  - Sub-module piso_lsb #(WIDTH): loadable LSB-first shift register with load/shift/bit_out.
//    Instantiated twice, once for A and once for B. FSM and counter stay in the top.
// TESTING (bench instantiates comparator_seq_tx driving a real comparator_seq; clk period 10)
//  1 WIDTH=8, A=0x5A, B=0x5A -> res_eq=1, gt=lt=err=0; res_valid first high 10 cycles after accept.
//  2 A=0x80, B=0x7F (MSB decides) -> res_gt=1. Then A=0x01, B=0x02 -> res_lt=1. Serial trace LSB-first.
//  3 Backpressure: res_ready=0 for 5 cycles in DONE -> res_* stable, in_ready=0, in_valid held is not
//    accepted; res_ready=1 -> IDLE next cycle, then accept.
//  4 Reset asserted in SHIFT cnt=3 -> next cycle all outputs at reset values, no res_valid;
//    the following pair A=3, B=3 yields res_eq=1 (comparator was re-cleared).
//  5 WIDTH=1 build: A=1, B=0 -> gt; A=0, B=0 -> eq; res_valid 3 cycles after accept.
//  6 Force cmp_gt=cmp_lt=1 via stub comparator on last bit -> res_err=1.
//  Randomised: 1000 pairs checked against A>B / A<B / A==B.

Source files
------------

// File: rtl/comparator_seq_tx_pkg.sv
// Shared definitions for the bit-serial compare link transmitter: FSM encodings,
// result flag bit positions and small elaboration helpers.
package comparator_seq_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Flag vector layout is {eq, gt, lt}; the comparator bench uses the same positions.
  localparam int FLAG_EQ = 2;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LT = 0;

  function automatic logic flags_onehot(input logic [2:0] f);
    return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
  endfunction

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/comparator_seq_tx_piso_lsb.sv
// Loadable parallel-in serial-out shift register; bit_out always presents the
// next LSB still to be sent.
module piso_lsb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_bit_out
);

  logic [WIDTH-1:0] r_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= r_sr >> 1;
    end
  end

  assign o_bit_out = r_sr[0];

endmodule

// File: rtl/comparator_seq_tx.sv
// Transmit side of the bit-serial compare link: accepts an operand pair, clears the
// comparator, streams bit pairs LSB-first and returns the sampled flags.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// CLEAR | one cycle holding the comparator clear, serial lines at 0
// SHIFT | WIDTH cycles driving bit cnt of A/B, flags captured on the last
// DONE  | result presented until the consumer takes it
module comparator_seq_tx
  import comparator_seq_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_a,
  output logic             ser_b,
  output logic             cmp_rst_n,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_eq,
  output logic             res_gt,
  output logic             res_lt,
  output logic             res_err
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_in_ready;
  logic            r_ser_a;
  logic            r_ser_b;
  logic            r_cmp_rst_n;
  logic            r_res_valid;
  logic            r_res_eq;
  logic            r_res_gt;
  logic            r_res_lt;
  logic            r_res_err;

  logic            w_accept;
  logic            w_last;
  logic            w_load;
  logic            w_shift;
  logic            w_bit_a;
  logic            w_bit_b;
  logic [2:0]      w_flags;

  assign w_accept = (r_state == ST_IDLE) && in_valid && r_in_ready;
  assign w_last   = (r_cnt == LAST);
  assign w_load   = w_accept;
  // CLEAR pre-loads bit 0, so every shift after that exposes the next bit for SHIFT.
  assign w_shift  = (r_state == ST_CLEAR) || ((r_state == ST_SHIFT) && !w_last);
  assign w_flags  = {cmp_eq, cmp_gt, cmp_lt};

  piso_lsb #(.WIDTH(WIDTH)) u_piso_a (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_shift   (w_shift),
    .i_data    (in_a),
    .o_bit_out (w_bit_a)
  );

  piso_lsb #(.WIDTH(WIDTH)) u_piso_b (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_shift   (w_shift),
    .i_data    (in_b),
    .o_bit_out (w_bit_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_ser_a     <= 1'b0;
      r_ser_b     <= 1'b0;
      r_cmp_rst_n <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_eq    <= 1'b0;
      r_res_gt    <= 1'b0;
      r_res_lt    <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_in_ready  <= 1'b0;
            r_cmp_rst_n <= 1'b0;
            r_cnt       <= '0;
            r_state     <= ST_CLEAR;
          end else begin
            r_in_ready  <= 1'b1;
            r_cmp_rst_n <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_cmp_rst_n <= 1'b1;
          r_ser_a     <= w_bit_a;
          r_ser_b     <= w_bit_b;
          r_state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_last) begin
            r_res_eq    <= w_flags[FLAG_EQ];
            r_res_gt    <= w_flags[FLAG_GT];
            r_res_lt    <= w_flags[FLAG_LT];
            r_res_err   <= !flags_onehot(w_flags);
            r_res_valid <= 1'b1;
            r_ser_a     <= 1'b0;
            r_ser_b     <= 1'b0;
            r_state     <= ST_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_ser_a <= w_bit_a;
            r_ser_b <= w_bit_b;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign ser_a     = r_ser_a;
  assign ser_b     = r_ser_b;
  assign cmp_rst_n = r_cmp_rst_n;
  assign res_valid = r_res_valid;
  assign res_eq    = r_res_eq;
  assign res_gt    = r_res_gt;
  assign res_lt    = r_res_lt;
  assign res_err   = r_res_err;

endmodule

// File: tb/tb_comparator_seq_tx.sv
// Bench for comparator_seq_tx: WIDTH=8 and WIDTH=1 instances, each driving a
// behavioural LSB-first serial comparator.
module tb_comparator_seq_tx;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, res_ready, sel, force_bad;
  logic [7:0] in_a, in_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic in_ready8, ser_a8, ser_b8, cmp_rst_n8, cmp_eq8, cmp_gt8, cmp_lt8;
  logic res_valid8, res_eq8, res_gt8, res_lt8, res_err8, m8_gt, m8_lt;
  logic in_valid8, res_ready8;
  assign in_valid8  = in_valid & ~sel;
  assign res_ready8 = res_ready & ~sel;

  comparator_seq_tx #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a), .in_b(in_b), .ser_a(ser_a8), .ser_b(ser_b8), .cmp_rst_n(cmp_rst_n8),
    .cmp_eq(cmp_eq8), .cmp_gt(cmp_gt8), .cmp_lt(cmp_lt8),
    .res_valid(res_valid8), .res_ready(res_ready8),
    .res_eq(res_eq8), .res_gt(res_gt8), .res_lt(res_lt8), .res_err(res_err8)
  );

  always @(posedge clk)
    if (!cmp_rst_n8) {m8_gt, m8_lt} <= 2'b00;
    else if (ser_a8 != ser_b8) {m8_gt, m8_lt} <= {ser_a8, ser_b8};

  assign cmp_gt8 = force_bad | (ser_a8 & ~ser_b8) | ((ser_a8 == ser_b8) & m8_gt);
  assign cmp_lt8 = force_bad | (~ser_a8 & ser_b8) | ((ser_a8 == ser_b8) & m8_lt);
  assign cmp_eq8 = ~cmp_gt8 & ~cmp_lt8;

  // WIDTH=1 instance
  logic in_ready1, ser_a1, ser_b1, cmp_rst_n1, cmp_eq1, cmp_gt1, cmp_lt1;
  logic res_valid1, res_eq1, res_gt1, res_lt1, res_err1, m1_gt, m1_lt;
  logic in_valid1, res_ready1;
  logic [0:0] in_a1, in_b1;
  assign in_valid1  = in_valid & sel;
  assign res_ready1 = res_ready & sel;
  assign in_a1 = in_a[0];
  assign in_b1 = in_b[0];

  comparator_seq_tx #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .ser_a(ser_a1), .ser_b(ser_b1), .cmp_rst_n(cmp_rst_n1),
    .cmp_eq(cmp_eq1), .cmp_gt(cmp_gt1), .cmp_lt(cmp_lt1),
    .res_valid(res_valid1), .res_ready(res_ready1),
    .res_eq(res_eq1), .res_gt(res_gt1), .res_lt(res_lt1), .res_err(res_err1)
  );

  always @(posedge clk)
    if (!cmp_rst_n1) {m1_gt, m1_lt} <= 2'b00;
    else if (ser_a1 != ser_b1) {m1_gt, m1_lt} <= {ser_a1, ser_b1};

  assign cmp_gt1 = (ser_a1 & ~ser_b1) | ((ser_a1 == ser_b1) & m1_gt);
  assign cmp_lt1 = (~ser_a1 & ser_b1) | ((ser_a1 == ser_b1) & m1_lt);
  assign cmp_eq1 = ~cmp_gt1 & ~cmp_lt1;

  // Selected-instance views
  logic in_ready_m, ser_a_m, ser_b_m, cmp_rst_n_m, res_valid_m;
  logic [3:0] flags_m;
  assign in_ready_m  = sel ? in_ready1  : in_ready8;
  assign ser_a_m     = sel ? ser_a1     : ser_a8;
  assign ser_b_m     = sel ? ser_b1     : ser_b8;
  assign cmp_rst_n_m = sel ? cmp_rst_n1 : cmp_rst_n8;
  assign res_valid_m = sel ? res_valid1 : res_valid8;
  assign flags_m     = sel ? {res_eq1, res_gt1, res_lt1, res_err1}
                           : {res_eq8, res_gt8, res_lt8, res_err8};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp = {eq, gt, lt, err}
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int hold,
                         input logic [3:0] exp, input string nm);
    int w, n, lat;
    logic [7:0] sa, sb, mask;
    logic rst_bad;
    logic [3:0] held;
    w = sel ? 1 : 8;
    mask = sel ? 8'h01 : 8'hFF;
    n = 0;
    while (!in_ready_m && n < 30) begin tick(); n++; end
    check({nm, " ready"}, 32'(in_ready_m), 32'd1);
    in_a = a; in_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1; sa = '0; sb = '0; rst_bad = 1'b0;
    check({nm, " clear"}, {28'd0, in_ready_m, cmp_rst_n_m, ser_a_m, ser_b_m}, 32'd0);
    while (!res_valid_m && lat < 40) begin
      tick();
      lat++;
      if (lat >= 2 && lat <= w + 1) begin
        sa[lat-2] = ser_a_m;
        sb[lat-2] = ser_b_m;
        if (!cmp_rst_n_m) rst_bad = 1'b1;
      end
    end
    check({nm, " latency"}, 32'(lat), 32'(w + 2));
    check({nm, " trace"}, {16'd0, sa, sb}, {16'd0, a & mask, b & mask});
    check({nm, " shift_rst_n"}, 32'(rst_bad), 32'd0);
    check({nm, " flags"}, 32'(flags_m), 32'(exp));
    check({nm, " ser_idle"}, {30'd0, ser_a_m, ser_b_m}, 32'd0);
    held = flags_m;
    in_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({nm, " hold"}, {26'd0, res_valid_m, in_ready_m, flags_m}, {26'd0, 2'b10, held});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    in_valid = 1'b0;
    check({nm, " release"}, {30'd0, res_valid_m, in_ready_m}, 32'd1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] ra, rb;
    logic [3:0] rexp;
    logic seen;
    vecs[0] = '{8'h5A, 8'h5A, 4'b1000};
    vecs[1] = '{8'h80, 8'h7F, 4'b0100};
    vecs[2] = '{8'h01, 8'h02, 4'b0010};
    vecs[3] = '{8'h00, 8'h00, 4'b1000};
    vecs[4] = '{8'hFF, 8'hFF, 4'b1000};
    vecs[5] = '{8'hFF, 8'h00, 4'b0100};
    vecs[6] = '{8'h00, 8'hFF, 4'b0010};
    vecs[7] = '{8'h7F, 8'h80, 4'b0010};
    vecs[8] = '{8'h81, 8'h80, 4'b0100};
    vecs[9] = '{8'hA5, 8'h5A, 4'b0100};

    reset = 1'b1; in_valid = 1'b0; res_ready = 1'b0; sel = 1'b0; force_bad = 1'b0;
    in_a = '0; in_b = '0;
    repeat (3) tick();
    check("reset_outputs", {23'd0, in_ready8, ser_a8, ser_b8, cmp_rst_n8, res_valid8,
                            res_eq8, res_gt8, res_lt8, res_err8}, 32'd0);
    reset = 1'b0;
    tick();
    check("post_reset_idle", {30'd0, in_ready8, cmp_rst_n8}, 32'd3);

    for (int i = 0; i < 10; i++)
      run_txn(vecs[i].a, vecs[i].b, 0, vecs[i].exp, $sformatf("vec%0d", i));

    run_txn(8'h3C, 8'h3D, 5, 4'b0010, "backpressure");
    run_txn(8'h12, 8'h11, 0, 4'b0100, "after_bp");

    // Abort in SHIFT with cnt=3, then check the comparator starts clean again.
    in_a = 8'h0F; in_b = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("abort_bit3", {30'd0, ser_a8, ser_b8}, 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_outputs", {23'd0, in_ready8, ser_a8, ser_b8, cmp_rst_n8, res_valid8,
                            res_eq8, res_gt8, res_lt8, res_err8}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (res_valid8) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    run_txn(8'h03, 8'h03, 0, 4'b1000, "after_abort");

    force_bad = 1'b1;
    run_txn(8'h5A, 8'h5A, 0, 4'b0111, "forced_err");
    force_bad = 1'b0;

    sel = 1'b1;
    tick();
    run_txn(8'h01, 8'h00, 0, 4'b0100, "w1_gt");
    run_txn(8'h00, 8'h00, 0, 4'b1000, "w1_eq");
    run_txn(8'h00, 8'h01, 0, 4'b0010, "w1_lt");
    run_txn(8'h01, 8'h01, 2, 4'b1000, "w1_bp");
    sel = 1'b0;
    tick();

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 4 == 0) ? ra : 8'($urandom_range(0, 255));
      rexp = (ra > rb) ? 4'b0100 : (ra < rb) ? 4'b0010 : 4'b1000;
      run_txn(ra, rb, 0, rexp, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
